// File: rtl/shift_req_arbiter_if.sv
// rtl/shift_req_arbiter_if.sv - requester/response bundle for the shared shifter arbiter
interface shift_req_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_data;
  logic [5*N_REQ-1:0]  req_amt;
  logic [N_REQ-1:0]    req_dir;
  logic [N_REQ-1:0]    req_rot;
  logic                resp_valid;
  logic                resp_ready;
  logic [31:0]         resp_data;
  logic [ID_W-1:0]     resp_id;
  logic                busy;

  modport master (
    output req_valid, req_data, req_amt, req_dir, req_rot, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_dir, req_rot, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, busy
  );
endinterface

// File: rtl/shift_req_arbiter.sv
// rtl/shift_req_arbiter.sv - round-robin arbiter sharing one 32-bit barrel shifter
module shift_req_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  shift_req_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  int              scan;

  logic [ID_W-1:0] op_id;
  logic [31:0]     op_data;
  logic [4:0]      op_amt;
  logic            op_dir;
  logic            op_rot;

  logic [63:0]     rot_l;
  logic [63:0]     rot_r;
  logic [31:0]     shift_out;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= N_REQ) scan = scan - N_REQ;
      if (!grant_found && bus.req_valid[ID_W'(scan)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(scan);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && !rst && grant_found) bus.req_ready[grant_idx] = 1'b1;
  end

  // Rotates take the matching half of the operand concatenated with itself.
  always_comb begin
    rot_l     = {op_data, op_data} << op_amt;
    rot_r     = {op_data, op_data} >> op_amt;
    shift_out = op_data;
    if (op_rot) shift_out = op_dir ? rot_r[31:0] : rot_l[63:32];
    else        shift_out = op_dir ? (op_data >> op_amt) : (op_data << op_amt);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      op_id          <= '0;
      op_data        <= '0;
      op_amt         <= '0;
      op_dir         <= 1'b0;
      op_rot         <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_id   <= grant_idx;
            op_data <= bus.req_data[32*grant_idx +: 32];
            op_amt  <= bus.req_amt[5*grant_idx +: 5];
            op_dir  <= bus.req_dir[grant_idx];
            op_rot  <= bus.req_rot[grant_idx];
          end
        end
        EXEC: begin
          bus.resp_data  <= shift_out;
          bus.resp_id    <= op_id;
          bus.resp_valid <= 1'b1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            rr_ptr <= (op_id == ID_W'(N_REQ - 1)) ? '0 : op_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
endmodule
